// File: rtl/fault_injector.sv
`default_nettype none
// ============================================================================
// Module      : fault_injector
// Description : Sequenced single-replica fault source placed between the
//               replica outputs and the majority voter. Optional random
//               target/bit selection is built when FAULT_INJECTOR_RANDOM_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fault_injector #(
    parameter int WIDTH = 32,
    parameter int NREP  = 5,
    parameter int BITW  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [2:0]            target,
    input  logic [BITW-1:0]       bitsel,
    input  logic [15:0]           delay,
    input  logic [15:0]           duration,
    input  logic                  rand_sel,
    input  logic [NREP*WIDTH-1:0] data_in,
    output logic [NREP*WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  inject_active,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            fault_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_INJECT = 2'd2
    } state_t;

    localparam logic [3:0]    c_nrep  = 4'(NREP);
    localparam logic [BITW:0] c_width = (BITW+1)'(WIDTH);

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     dur_q, dur_d;
    logic [1:0]      mode_q, mode_d;
    logic [2:0]      target_q, target_d;
    logic [BITW-1:0] bitsel_q, bitsel_d;
    logic            busy_q, busy_d;
    logic            active_q, active_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      count_q, count_d;

    logic [2:0]      w_sel_target;
    logic [BITW-1:0] w_sel_bit;
    logic            w_sel_ok;

`ifdef FAULT_INJECTOR_RANDOM_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end

    // Random picks are reduced modulo the bus geometry, so they are always legal.
    always_comb begin
        if (rand_sel) begin
            w_sel_target = 3'(lfsr_q[7:0] % 8'(NREP));
            w_sel_bit    = BITW'({1'b0, lfsr_q[15:8]} % 9'(WIDTH));
            w_sel_ok     = 1'b1;
        end else begin
            w_sel_target = target;
            w_sel_bit    = bitsel;
            w_sel_ok     = ({1'b0, target} < c_nrep) && ({1'b0, bitsel} < c_width);
        end
    end
`else
    logic unused_rand_sel;
    assign unused_rand_sel = rand_sel;
    assign w_sel_target    = target;
    assign w_sel_bit       = bitsel;
    assign w_sel_ok        = ({1'b0, target} < c_nrep) && ({1'b0, bitsel} < c_width);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dur_d    = dur_q;
        mode_d   = mode_q;
        target_d = target_q;
        bitsel_d = bitsel_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (w_sel_ok) begin
                        mode_d   = mode;
                        target_d = w_sel_target;
                        bitsel_d = w_sel_bit;
                        dur_d    = duration;
                        if (delay == 16'd0) begin
                            state_d = ST_INJECT;
                            cnt_d   = duration;
                        end else begin
                            state_d = ST_ARMED;
                            cnt_d   = delay;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 16'd1) begin
                    state_d = ST_INJECT;
                    cnt_d   = dur_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_INJECT: begin
                // A zero duration never counts down: the fault is permanent.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (dur_q != 16'd0) begin
                    if (cnt_q == 16'd1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (count_q != 8'hFF) count_d = count_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d   = (state_d != ST_IDLE);
        active_d = (state_d == ST_INJECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dur_q    <= '0;
            mode_q   <= '0;
            target_q <= '0;
            bitsel_q <= '0;
            busy_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dur_q    <= dur_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            bitsel_q <= bitsel_d;
            busy_q   <= busy_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign busy          = busy_q;
    assign inject_active = active_q;
    assign done          = done_q;
    assign err           = err_q;
    assign fault_count   = count_q;

    logic [WIDTH-1:0] w_mask;
    assign w_mask = WIDTH'(1) << bitsel_q;

    generate
        for (genvar r = 0; r < NREP; r++) begin : g_rep
            logic [WIDTH-1:0] w_in;
            logic [WIDTH-1:0] w_hit;
            assign w_in = data_in[r*WIDTH +: WIDTH];
            always_comb begin
                w_hit = w_in;
                case (mode_q)
                    2'b00:   w_hit = w_in & ~w_mask;
                    2'b01:   w_hit = w_in | w_mask;
                    2'b10:   w_hit = w_in ^ w_mask;
                    default: w_hit = '0;
                endcase
            end
            assign data_out[r*WIDTH +: WIDTH] =
                (active_q && (target_q == 3'(r))) ? w_hit : w_in;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fault_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fault_injector
// Description : Self-checking bench for fault_injector with a behavioural
//               timing/corruption model and randomized injections.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fault_injector;

    localparam int WIDTH = 32;
    localparam int NREP  = 5;
    localparam int BITW  = 5;
    localparam int DW    = NREP * WIDTH;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [1:0]      mode = '0;
    logic [2:0]      target = '0;
    logic [BITW-1:0] bitsel = '0;
    logic [15:0]     delay = '0;
    logic [15:0]     duration = '0;
    logic            rand_sel = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic [DW-1:0]   data_out;
    logic            busy, inject_active, done, err;
    logic [7:0]      fault_count;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_count = 0;
    logic [DW-1:0] snap;

    fault_injector #(.WIDTH(WIDTH), .NREP(NREP), .BITW(BITW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .target(target), .bitsel(bitsel), .delay(delay), .duration(duration),
        .rand_sel(rand_sel), .data_in(data_in), .data_out(data_out),
        .busy(busy), .inject_active(inject_active), .done(done), .err(err),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

`ifdef FAULT_INJECTOR_RANDOM_EN
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        int fb;
        fb = ((int'(l) >> 0) ^ (int'(l) >> 2) ^ (int'(l) >> 3) ^ (int'(l) >> 5)) & 1;
        return 16'((int'(l) >> 1) | (fb << 15));
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end
`endif

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int r = 0; r < NREP; r++) v[r*WIDTH +: WIDTH] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_out(input logic [DW-1:0] din, input bit act,
                                              input int m, input int t, input int b);
        logic [DW-1:0]    res;
        logic [WIDTH-1:0] w;
        res = din;
        if (act) begin
            w = din[t*WIDTH +: WIDTH];
            case (m)
                0:       w[b] = 1'b0;
                1:       w[b] = 1'b1;
                2:       w[b] = ~w[b];
                default: w = '0;
            endcase
            res[t*WIDTH +: WIDTH] = w;
        end
        return res;
    endfunction

    // One complete injection, checked every cycle from T+1 to the done cycle.
    task automatic run_inj(input int m, input int t, input int b, input int dly,
                           input int dur, input bit rs, input bit rnd);
        int mt, mb;
        bit act;
        @(negedge clk);
        mode = 2'(m); target = 3'(t); bitsel = BITW'(b);
        delay = 16'(dly); duration = 16'(dur); rand_sel = rs; start = 1'b1;
        mt = t; mb = b;
`ifdef FAULT_INJECTOR_RANDOM_EN
        if (rs) begin
            mt = int'(m_lfsr[7:0]) % NREP;
            mb = int'(m_lfsr[15:8]) % WIDTH;
        end
`endif
        for (int k = 1; k <= dly + dur + 1; k++) begin
            @(negedge clk);
            start = 1'b0; rand_sel = 1'b0;
            if (rnd) data_in = rand_data();
            #1;
            act = (k >= dly + 1) && (k <= dly + dur);
            if (k == dly + dur + 1 && exp_count < 255) exp_count++;
            if (act && k == dly + 1) snap = data_out;
            chk("busy", DW'(busy), DW'(k <= dly + dur));
            chk("inject_active", DW'(inject_active), DW'(act));
            chk("done", DW'(done), DW'(k == dly + dur + 1));
            chk("err", DW'(err), '0);
            chk("data_out", data_out, exp_out(data_in, act, m, mt, mb));
            chk("fault_count", DW'(fault_count), DW'(exp_count));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_count = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NREP; r++) data_in[r*WIDTH +: WIDTH] = 32'h0000_00F0 + 32'(r);
        #1;
        chk("rst_data_out", data_out, data_in);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_inject", DW'(inject_active), '0);
        chk("rst_done", DW'(done), '0);
        chk("rst_err", DW'(err), '0);
        chk("rst_count", DW'(fault_count), '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed bit-flip on replica 2 bit 4
        run_inj(2, 2, 4, 3, 2, 1'b0, 1'b0);
        chk("flip_slice2", DW'(snap[2*WIDTH +: WIDTH]), DW'(32'h0000_00E2));
        chk("flip_count", DW'(fault_count), DW'(1));

        // Randomized injections with changing replica data
        for (int i = 0; i < 10; i++)
            run_inj($urandom_range(0, 3), $urandom_range(0, NREP - 1), $urandom_range(0, WIDTH - 1),
                    $urandom_range(0, 4), $urandom_range(1, 4), 1'b0, 1'b1);

        // Permanent whole-replica kill, then stop
        @(negedge clk);
        mode = 2'b11; target = 3'd0; bitsel = '0; delay = 16'd0; duration = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            data_in = rand_data();
            #1;
            chk("perm_inject", DW'(inject_active), DW'(1));
            chk("perm_slice0", DW'(data_out[WIDTH-1:0]), '0);
            chk("perm_done", DW'(done), '0);
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        chk("stop_inject", DW'(inject_active), '0);
        chk("stop_data", data_out, data_in);
        chk("stop_busy", DW'(busy), '0);
        chk("stop_count", DW'(fault_count), DW'(exp_count));

        // Rejected start on an out-of-range replica
        @(negedge clk);
        mode = 2'b10; target = 3'd5; bitsel = '0; delay = 16'd2; duration = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("err_pulse", DW'(err), DW'(1));
        chk("err_busy", DW'(busy), '0);
        @(negedge clk);
        #1;
        chk("err_clear", DW'(err), '0);
        chk("err_busy2", DW'(busy), '0);
        run_inj(0, 1, 7, 1, 3, 1'b0, 1'b1);

        // Stop while armed: no completion and no count
        @(negedge clk);
        mode = 2'b01; target = 3'd3; bitsel = 5'd9; delay = 16'd5; duration = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("armed_busy", DW'(busy), DW'(1));
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        chk("armed_stop_busy", DW'(busy), '0);
        chk("armed_stop_inject", DW'(inject_active), '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("armed_stop_done", DW'(done), '0);
        end
        chk("armed_stop_count", DW'(fault_count), DW'(exp_count));

        // Second start ignored mid-window, then asynchronous reset
        @(negedge clk);
        mode = 2'b01; target = 3'd4; bitsel = 5'd31; delay = 16'd1; duration = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_inject", DW'(inject_active), DW'(1));
        chk("mid_data", data_out, exp_out(data_in, 1'b1, 1, 4, 31));
        mode = 2'b11; target = 3'd0; delay = 16'd0; duration = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("ignored_err", DW'(err), '0);
        chk("ignored_busy", DW'(busy), DW'(1));
        chk("ignored_data", data_out, exp_out(data_in, 1'b1, 1, 4, 31));
        #2;
        reset = 1'b1;
        exp_count = 0;
        #1;
        chk("arst_data", data_out, data_in);
        chk("arst_inject", DW'(inject_active), '0);
        chk("arst_busy", DW'(busy), '0);
        chk("arst_done", DW'(done), '0);
        chk("arst_err", DW'(err), '0);
        chk("arst_count", DW'(fault_count), '0);
        @(negedge clk);
        reset = 1'b0;

`ifdef FAULT_INJECTOR_RANDOM_EN
        // Random selection: target port deliberately out of range
        do_reset();
        for (int i = 0; i < 20; i++) run_inj(2, 7, 0, 0, 1, 1'b1, 1'b1);
        chk("rand_count", DW'(fault_count), DW'(20));
`else
        // Without the random build, rand_sel has no effect
        do_reset();
        run_inj(2, 3, 17, 2, 2, 1'b1, 1'b1);
        chk("norand_count", DW'(fault_count), DW'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fault_injector.md
Name: fault_injector

Overview:
- Sequenced fault source for the N-modular-redundant datapath (5-replica ALU plus majority voter).
- Sits between the replica outputs and the voter inputs. Corrupts one selected replica's word for a programmed window, so voter masking and replica switch-off can be exercised in simulation and on FPGA.
- Controlled by a test sequencer through a start/busy/done handshake.

Parameters:
- WIDTH, 32, bits per replica word.
- NREP, 5, number of replicas on the bus (2..8).
- BITW, 5, width of bit-index port; must satisfy 2**BITW >= WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to arm an injection; sampled only in IDLE.
- stop  in  1  abort; returns the block to IDLE.
- mode  in  2  00 stuck-at-0 bit, 01 stuck-at-1 bit, 10 bit-flip, 11 whole replica forced to 0.
- target  in  3  replica index.
- bitsel  in  BITW  bit index within the replica word.
- delay  in  16  cycles from acceptance to fault onset.
- duration  in  16  fault length in cycles; 0 = permanent until stop or reset.
- rand_sel  in  1  random target/bit request (see Optional Feature).
- data_in  in  NREP*WIDTH  replica words; replica r occupies [r*WIDTH +: WIDTH].
- data_out  out  NREP*WIDTH  possibly corrupted replica words.
- busy  out  1  high in ARMED or INJECT.
- inject_active  out  1  high while the fault is applied.
- done  out  1  one-cycle pulse on natural completion.
- err  out  1  one-cycle pulse when start is rejected.
- fault_count  out  8  saturating count of completed injections.

Behaviour:
- Reset: state IDLE. busy, inject_active, done, err = 0. fault_count = 0. Latched config = 0. data_out == data_in.
- data_out path is combinational, with zero latency from data_in. Only the latched target slice is modified, and only while inject_active = 1.
  - Mode 00: bit cleared.
  - Mode 01: bit set.
  - Mode 10: bit inverted.
  - Mode 11: whole slice = 0.
  - All other slices always pass through unmodified.
- All control outputs are registered.
- IDLE:
  - start=1, stop=0, target<NREP, bitsel<WIDTH: latch mode/target/bitsel/delay/duration. Next state is ARMED, or INJECT directly if delay=0.
  - start=1 with target>=NREP or bitsel>=WIDTH: stay in IDLE and pulse err for one cycle the next cycle. Config is not latched.
  - start and stop together: stop wins, nothing happens.
- Timing, with start accepted at edge T:
  - busy is high from cycle T+1.
  - inject_active is high for cycles T+1+delay through T+delay+duration.
  - done is high in cycle T+1+delay+duration.
  - State returns to IDLE in that same cycle, so busy=0 while done=1.
  - fault_count increments with done and saturates at 255.
- duration=0: the block stays in INJECT indefinitely. It never pulses done.
- start while busy: ignored. No err, and config is unchanged.
- stop in ARMED or INJECT: next state IDLE, inject_active=0 from the next cycle. No done pulse, no count increment.
- Counters are 16-bit down-counters. No wrap: delay=16'hFFFF gives exactly 65535 armed cycles.
- Reset mid-operation: immediate return to IDLE. Corruption disappears asynchronously and fault_count is cleared.
- States: IDLE, ARMED, INJECT. done is a registered flag, not a state.

Optional Feature:
- Macro: FAULT_INJECTOR_RANDOM_EN.
- Defined:
  - A 16-bit Fibonacci LFSR runs every cycle. Taps 16,14,13,11; seed 16'hACE1 on reset; it never holds zero.
  - On accepted start with rand_sel=1: latched target = lfsr[7:0] mod NREP and bit = lfsr[15:8] mod WIDTH. The target and bitsel ports are ignored, and err is never raised for them.
- Undefined: no LFSR logic. rand_sel is ignored and target/bitsel are always used.

Test Plan:
- Reset, then apply data_in slice r = 32'h0000_00F0 + r. Expect data_out == data_in, busy=0, fault_count=0.
- start with mode=10, target=2, bitsel=4, delay=3, duration=2 at edge T, slice2=32'h0000_00F2.
  - inject_active in cycles T+4 and T+5, with slice2 out = 32'h0000_00E2 and the other slices unchanged.
  - done at T+6; fault_count=1.
- start with mode=11, target=0, delay=0, duration=0.
  - slice0 out = 0 from T+1 onward; no done after 1000 cycles.
  - stop: inject_active=0 and data_out==data_in next cycle; fault_count unchanged.
- start with target=5 (NREP=5). Expect err pulse at T+1, busy stays 0, and a later valid start is accepted normally.
- While INJECT with mode=01, target=4, bit=31: a second start is ignored. Assert reset mid-window: slice4 reverts immediately and all outputs return to reset values.
- Macro defined, rand_sel=1, 20 sequential injections with delay=0, duration=1: every latched target < 5 and bit < 32; targets match a reference LFSR model; fault_count=20.
